// File: rtl/ones_seq_pkg.sv
// Shared definitions for the ones-count sequencer: FSM encoding, chunk width and
// the count-width helper.
package ones_seq_pkg;

    localparam int unsigned CHUNK_W = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDrive  = 3'd1,
        StSettle = 3'd2,
        StAccum  = 3'd3,
        StDone   = 3'd4
    } seq_state_e;

    // Bits needed to hold a popcount of 0..w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that holds off sampling of the ones-counter cell; o_expire is high
// on the cycle the count reaches 1.
module settle_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/ones_count_sequencer.sv
// Popcount sequencer driving an external 3-input ones-counter cell one chunk at a time.
// Optional result checker on the cell enabled by defining ONES_CNT_CHECK_EN (adds o_err).
module ones_count_sequencer
    import ones_seq_pkg::*;
#(
    parameter int unsigned N_CHUNKS      = 8,
    parameter int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned W            = CHUNK_W * N_CHUNKS,
    localparam int unsigned CW           = cnt_width(W)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [W-1:0]  i_data_in,
    output logic          o_cell_a,
    output logic          o_cell_b,
    output logic          o_cell_c,
    input  logic          i_cell_y0,
    input  logic          i_cell_y1,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_count
`ifdef ONES_CNT_CHECK_EN
    ,
    output logic          o_err
`endif
);

    localparam int unsigned IW = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int unsigned TW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    seq_state_e    r_state;
    logic [W-1:0]  r_shift;
    logic [CW-1:0] r_acc;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_idx;
    logic [2:0]    r_cell;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_y;
    logic [CW-1:0] w_acc_sum;
    logic [W-1:0]  w_shift_next;
    logic          w_last;
    logic          w_load;
    logic          w_expire;

    assign w_y          = {i_cell_y1, i_cell_y0};
    assign w_acc_sum    = r_acc + CW'(w_y);
    assign w_shift_next = r_shift >> CHUNK_W;
    assign w_last       = (r_idx == IW'(N_CHUNKS - 1));
    assign w_load       = (r_state == StDrive);

    settle_timer #(
        .WIDTH (TW)
    ) u_settle_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_value  (TW'(SETTLE_CYCLES)),
        .o_expire (w_expire)
    );

    // Slice bits are registered alongside the state so they change only at chunk boundaries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_cell  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_shift <= i_data_in;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_cell  <= i_data_in[2:0];
                        r_busy  <= 1'b1;
                        r_state <= StDrive;
                    end
                end
                StDrive: begin
                    r_state <= (SETTLE_CYCLES == 0) ? StAccum : StSettle;
                end
                StSettle: begin
                    if (w_expire) begin
                        r_state <= StAccum;
                    end
                end
                StAccum: begin
                    r_acc   <= w_acc_sum;
                    r_shift <= w_shift_next;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        // Final sum goes straight to count so it is valid alongside done.
                        r_count <= w_acc_sum;
                        r_done  <= 1'b1;
                        r_cell  <= '0;
                        r_state <= StDone;
                    end else begin
                        r_cell  <= w_shift_next[2:0];
                        r_state <= StDrive;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cell_a = r_cell[2];
    assign o_cell_b = r_cell[1];
    assign o_cell_c = r_cell[0];
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_count  = r_count;

`ifdef ONES_CNT_CHECK_EN
    logic r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (r_state == StIdle && i_start) begin
            r_err <= 1'b0;
        end else if (r_state == StAccum && pop3(r_cell) != w_y) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Directed self-checking bench for ones_count_sequencer with a behavioural ones-counter cell;
// the delayed-cell checker scenario is built only when ONES_CNT_CHECK_EN is defined.
module tb_ones_count_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] data;
    logic        cell_a, cell_b, cell_c;
    logic        cell_y0, cell_y1;
    logic        busy, done;
    logic [4:0]  count;
    logic [1:0]  cell_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign cell_sum = {1'b0, cell_a} + {1'b0, cell_b} + {1'b0, cell_c};
    assign cell_y0  = cell_sum[0];
    assign cell_y1  = cell_sum[1];

`ifdef ONES_CNT_CHECK_EN
    logic err;
`endif

    ones_count_sequencer #(
        .N_CHUNKS      (8),
        .SETTLE_CYCLES (1)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_data_in (data),
        .o_cell_a  (cell_a),
        .o_cell_b  (cell_b),
        .o_cell_c  (cell_c),
        .i_cell_y0 (cell_y0),
        .i_cell_y1 (cell_y1),
        .o_busy    (busy),
        .o_done    (done),
        .o_count   (count)
`ifdef ONES_CNT_CHECK_EN
        ,
        .o_err     (err)
`endif
    );

`ifdef ONES_CNT_CHECK_EN
    // Two extra DUTs on a slow cell model: output lags the inputs by three registers.
    logic        e_start;
    logic [23:0] e_data;
    logic [2:0]  s1_abc, s1_d1, s1_d2, s1_d3;
    logic [2:0]  s3_abc, s3_d1, s3_d2, s3_d3;
    logic [1:0]  s1_y, s3_y;
    logic        s1_busy, s1_done, s1_err, s3_busy, s3_done, s3_err;
    logic [4:0]  s1_count, s3_count;

    always_ff @(posedge clk) begin
        s1_d1 <= s1_abc; s1_d2 <= s1_d1; s1_d3 <= s1_d2;
        s3_d1 <= s3_abc; s3_d2 <= s3_d1; s3_d3 <= s3_d2;
    end
    assign s1_y = {1'b0, s1_d3[0]} + {1'b0, s1_d3[1]} + {1'b0, s1_d3[2]};
    assign s3_y = {1'b0, s3_d3[0]} + {1'b0, s3_d3[1]} + {1'b0, s3_d3[2]};

    ones_count_sequencer #(.N_CHUNKS(8), .SETTLE_CYCLES(1)) u_dut_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .i_data_in(e_data),
        .o_cell_a(s1_abc[2]), .o_cell_b(s1_abc[1]), .o_cell_c(s1_abc[0]),
        .i_cell_y0(s1_y[0]), .i_cell_y1(s1_y[1]),
        .o_busy(s1_busy), .o_done(s1_done), .o_count(s1_count), .o_err(s1_err)
    );

    ones_count_sequencer #(.N_CHUNKS(8), .SETTLE_CYCLES(3)) u_dut_s3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .i_data_in(e_data),
        .o_cell_a(s3_abc[2]), .o_cell_b(s3_abc[1]), .o_cell_c(s3_abc[0]),
        .i_cell_y0(s3_y[0]), .i_cell_y1(s3_y[1]),
        .o_busy(s3_busy), .o_done(s3_done), .o_count(s3_count), .o_err(s3_err)
    );
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One start pulse, then 40 sampled cycles; cycle k is sampled 1 time unit after edge k.
    task automatic run_op(input logic [23:0] word, input int restart_cyc,
                          output int done_cyc, output int n_done, output int busy_err,
                          output int abc_nz, output logic [2:0] abc1,
                          output logic [4:0] cnt_pre, output logic [4:0] cnt_done);
        done_cyc = -1; n_done = 0; busy_err = 0; abc_nz = 0;
        abc1 = '0; cnt_pre = '0; cnt_done = '0;
        data  = word;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    cnt_done = count;
                end
            end
            if (busy !== (k <= 25)) busy_err++;
            if ({cell_a, cell_b, cell_c} != 3'b000) abc_nz++;
            if (k == 1) abc1 = {cell_a, cell_b, cell_c};
            if (k == 24) cnt_pre = count;
            start = (k == restart_cyc);
        end
        start = 1'b0;
    endtask

    initial begin
        int         dcyc, nd, berr, nz, d1, d2;
        logic [2:0] a1;
        logic [4:0] cpre, cdone;

        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
`ifdef ONES_CNT_CHECK_EN
        e_start = 1'b0;
        e_data  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_count", count, 0);
        check_eq("reset_abc", {cell_a, cell_b, cell_c}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(24'hFFFFFF, 0, dcyc, nd, berr, nz, a1, cpre, cdone);
        check_eq("ff_done_cycle", dcyc, 25);
        check_eq("ff_done_pulses", nd, 1);
        check_eq("ff_busy_window", berr, 0);
        check_eq("ff_count", cdone, 24);

        run_op(24'h000000, 0, dcyc, nd, berr, nz, a1, cpre, cdone);
        check_eq("zero_count", cdone, 0);
        check_eq("zero_abc_quiet", nz, 0);
        check_eq("zero_done_cycle", dcyc, 25);

        run_op(24'h924924, 0, dcyc, nd, berr, nz, a1, cpre, cdone);
        check_eq("onehot_count", cdone, 8);
        check_eq("onehot_chunk0_abc", a1, 3'b100);

        run_op(24'h000007, 5, dcyc, nd, berr, nz, a1, cpre, cdone);
        check_eq("restart_count", cdone, 3);
        check_eq("restart_pulses", nd, 1);
        check_eq("restart_done_cycle", dcyc, 25);
        check_eq("count_held", cpre, 8);
        check_eq("count_after", count, 3);

        // start held high: back-to-back operations separated by one idle cycle
        d1 = -1; d2 = -1; nd = 0;
        data  = 24'h000007;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) begin
                    d2 = k;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("hold_first_done", d1, 25);
        check_eq("hold_second_done", d2, 51);
        check_eq("hold_pulses", nd, 2);

        // Abort mid-operation with reset
        data  = 24'hFFFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check_eq("pre_reset_busy", busy, 1);
        check_eq("pre_reset_count", count, 3);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_count", count, 0);
        check_eq("abort_abc", {cell_a, cell_b, cell_c}, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check_eq("abort_no_done", nd, 0);

        run_op(24'h00000F, 0, dcyc, nd, berr, nz, a1, cpre, cdone);
        check_eq("post_reset_count", cdone, 4);
        check_eq("post_reset_done_cycle", dcyc, 25);

`ifdef ONES_CNT_CHECK_EN
        check_eq("main_err_clear", err, 0);
        e_data  = 24'h000005;
        e_start = 1'b1;
        @(posedge clk); #1;
        e_start = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check_eq("s1_err_set", s1_err, 1);
        repeat (40) begin
            @(posedge clk); #1;
        end
        check_eq("s1_err_sticky", s1_err, 1);
        check_eq("s3_err_clear", s3_err, 0);
        check_eq("s3_count", s3_count, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
